// File: rtl/estados_pkg.sv
// Shared codes for the game controller and the menu: FSM states, keypad codes
// and the result (v_d) encoding.
package estados_pkg;

    typedef enum logic [3:0] {
        APAGADO   = 4'd0,
        HOLA      = 4'd1,
        PERSONAJE = 4'd2,
        JUEGO     = 4'd3,
        GP        = 4'd4,
        YN        = 4'd5
    } estado_t;

    typedef enum logic [1:0] {
        VD_NADA   = 2'd0,
        VD_PIERDE = 2'd1,
        VD_GANA   = 2'd2
    } vd_t;

    localparam logic [4:0] KEY_SI    = 5'd10;
    localparam logic [4:0] KEY_NO    = 5'd11;
    localparam logic [4:0] KEY_HEROE = 5'd12;
    localparam logic [4:0] KEY_OK    = 5'd13;

    localparam int TIMER_W = 32;

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector on a registered previous value. An input already high
// when reset is released must drop once before it can produce an event.
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic flanco
);

    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= d;
            armed_q <= armed_q | ~d;
        end
    end

    assign flanco = d & ~prev_q & armed_q;

endmodule

// File: rtl/control_estado.sv
// Top-level game state controller: power, splash (HOLA), hero menu, game,
// game-over (GP) and play-again prompt (YN). Optional idle timeout: IDLE_TIMEOUT_EN.
module control_estado
    import estados_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 27_000_000,
    parameter int unsigned HOLA_CYC = 54_000_000,
    parameter int unsigned GP_CYC   = 81_000_000,
    parameter int unsigned IDLE_CYC = 810_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_encendido,
    input  logic       keypad_pressed,
    input  logic [4:0] key,
    input  logic       cambio,
    input  logic       vida_heroe_cero,
    input  logic       vida_enemigo_cero,
    output logic [3:0] presente,
    output logic       encendido,
    output logic [1:0] v_d,
    output logic       inicio
);

    localparam logic [TIMER_W-1:0] HOLA_LAST = TIMER_W'(HOLA_CYC - 1);
    localparam logic [TIMER_W-1:0] GP_LAST   = TIMER_W'(GP_CYC - 1);

    // CLK_HZ documents the clock the cycle counts were derived from.
`ifdef IDLE_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] IDLE_LAST = TIMER_W'(IDLE_CYC - 1);
    logic unused_cfg;
    assign unused_cfg = ^CLK_HZ;
`else
    logic unused_cfg;
    assign unused_cfg = ^{CLK_HZ, IDLE_CYC};
`endif

    logic ev_power;
    logic ev_key;

    detector_flanco u_det_power (
        .clk    (clk),
        .rst    (rst),
        .d      (btn_encendido),
        .flanco (ev_power)
    );

    detector_flanco u_det_key (
        .clk    (clk),
        .rst    (rst),
        .d      (keypad_pressed),
        .flanco (ev_key)
    );

    estado_t              estado_q, estado_d;
    vd_t                  vd_q, vd_d;
    logic                 inicio_q, inicio_d;
    logic                 encendido_q;
    logic                 timer_restart;
    logic [TIMER_W-1:0]   timer_q;

    always_comb begin
        estado_d      = estado_q;
        vd_d          = vd_q;
        inicio_d      = 1'b0;
        timer_restart = 1'b0;
        if (ev_power) begin
            estado_d = (estado_q == APAGADO) ? HOLA : APAGADO;
            vd_d     = VD_NADA;
        end else begin
            case (estado_q)
                APAGADO: vd_d = VD_NADA;
                HOLA: begin
                    if (timer_q == HOLA_LAST) estado_d = PERSONAJE;
                end
                PERSONAJE: begin
                    if (ev_key && key == KEY_OK && cambio) begin
                        estado_d = JUEGO;
                        inicio_d = 1'b1;
                    end
`ifdef IDLE_TIMEOUT_EN
                    else if (ev_key) begin
                        timer_restart = 1'b1;
                    end else if (timer_q == IDLE_LAST) begin
                        estado_d = HOLA;
                        vd_d     = VD_NADA;
                    end
`endif
                end
                JUEGO: begin
                    // Defeat takes precedence when both sides fall together.
                    if (vida_heroe_cero) begin
                        estado_d = GP;
                        vd_d     = VD_PIERDE;
                    end else if (vida_enemigo_cero) begin
                        estado_d = GP;
                        vd_d     = VD_GANA;
                    end
                end
                GP: begin
                    if (timer_q == GP_LAST) estado_d = YN;
                end
                YN: begin
                    if (ev_key && key == KEY_SI) begin
                        estado_d = PERSONAJE;
                        vd_d     = VD_NADA;
                    end else if (ev_key && key == KEY_NO) begin
                        estado_d = APAGADO;
                        vd_d     = VD_NADA;
                    end
`ifdef IDLE_TIMEOUT_EN
                    else if (ev_key) begin
                        timer_restart = 1'b1;
                    end else if (timer_q == IDLE_LAST) begin
                        estado_d = HOLA;
                        vd_d     = VD_NADA;
                    end
`endif
                end
                default: begin
                    estado_d = APAGADO;
                    vd_d     = VD_NADA;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= APAGADO;
            vd_q        <= VD_NADA;
            inicio_q    <= 1'b0;
            encendido_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            estado_q    <= estado_d;
            vd_q        <= vd_d;
            inicio_q    <= inicio_d;
            encendido_q <= (estado_d != APAGADO);
            // Saturating timer, restarted on every state change.
            if (estado_d != estado_q || timer_restart) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + 1'b1;
            end
        end
    end

    assign presente  = estado_q;
    assign encendido = encendido_q;
    assign v_d       = vd_q;
    assign inicio    = inicio_q;

endmodule

// File: tb/tb_control_estado.sv
// Directed bench for control_estado with a cycle-level behavioural model of the
// game flow; honours IDLE_TIMEOUT_EN the same way as the design build.
module tb_control_estado;

    localparam int HOLA = 4;
    localparam int GPC  = 3;
    localparam int IDLE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       kp = 1'b0;
    logic [4:0] key = 5'd0;
    logic       cambio = 1'b0;
    logic       vh = 1'b0;
    logic       ve = 1'b0;
    logic [3:0] presente;
    logic       encendido;
    logic [1:0] v_d;
    logic       inicio;

    control_estado #(
        .CLK_HZ   (27_000_000),
        .HOLA_CYC (HOLA),
        .GP_CYC   (GPC),
        .IDLE_CYC (IDLE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .btn_encendido     (btn),
        .keypad_pressed    (kp),
        .key               (key),
        .cambio            (cambio),
        .vida_heroe_cero   (vh),
        .vida_enemigo_cero (ve),
        .presente          (presente),
        .encendido         (encendido),
        .v_d               (v_d),
        .inicio            (inicio)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: screen number, result, cycles left in a timed screen, idle cycles.
    int m_pres = 0;
    int m_vd = 0;
    int m_left = 0;
    int m_idle = 0;
    bit m_ini = 0;
    bit pw_prev = 0, kp_prev = 0, pw_arm = 0, kp_arm = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        int np, nv;
        bit ni, pe, ke;
        if (rst) begin
            m_pres = 0; m_vd = 0; m_ini = 0; m_left = 0; m_idle = 0;
            pw_prev = 0; kp_prev = 0; pw_arm = 0; kp_arm = 0;
            return;
        end
        pe = btn && !pw_prev && pw_arm;
        ke = kp && !kp_prev && kp_arm;
        pw_arm = pw_arm | !btn;
        kp_arm = kp_arm | !kp;
        pw_prev = btn;
        kp_prev = kp;
        np = m_pres; nv = m_vd; ni = 0;
        if (pe) begin
            np = (m_pres == 0) ? 1 : 0;
            nv = 0;
        end else begin
            case (m_pres)
                1: if (m_left == 1) np = 2;
                2: if (ke && key == 5'd13 && cambio) begin np = 3; ni = 1; end
                3: if (vh) begin np = 4; nv = 1; end
                   else if (ve) begin np = 4; nv = 2; end
                4: if (m_left == 1) np = 5;
                5: if (ke && key == 5'd10) begin np = 2; nv = 0; end
                   else if (ke && key == 5'd11) begin np = 0; nv = 0; end
                default: ;
            endcase
`ifdef IDLE_TIMEOUT_EN
            if (np == m_pres && (m_pres == 2 || m_pres == 5) && !ke && m_idle + 1 >= IDLE) begin
                np = 1;
                nv = 0;
            end
`endif
        end
        if (np != m_pres) begin
            m_idle = 0;
            m_left = (np == 1) ? HOLA : (np == 4) ? GPC : 0;
        end else begin
            m_idle = ke ? 0 : m_idle + 1;
            m_left = m_left - 1;
        end
        m_pres = np;
        m_vd   = nv;
        m_ini  = ni;
    endfunction

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("presente", int'(presente), m_pres);
        check("encendido", int'(encendido), (m_pres != 0) ? 1 : 0);
        check("v_d", int'(v_d), m_vd);
        check("inicio", int'(inicio), int'(m_ini));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic power_pulse();
        btn = 1'b1; step();
        btn = 1'b0; step();
    endtask

    task automatic to_juego();
        if (m_pres != 0) power_pulse();
        power_pulse();
        steps(HOLA - 1);
        key = 5'd13; cambio = 1'b1; kp = 1'b1; step();
        kp = 1'b0;
    endtask

    task automatic goto_yn();
        to_juego();
        ve = 1'b1; step();
        ve = 1'b0;
        steps(GPC);
        check("lit_yn_reached", int'(presente), 5);
    endtask

    initial begin
        // Reset state
        steps(3);
        check("lit_reset_presente", int'(presente), 0);
        check("lit_reset_encendido", int'(encendido), 0);
        rst = 1'b0;
        steps(2);

        // Power on, HOLA lasts HOLA cycles
        btn = 1'b1; step();
        check("lit_hola", int'(presente), 1);
        check("lit_hola_enc", int'(encendido), 1);
        btn = 1'b0;
        steps(HOLA - 1);
        check("lit_hola_hold", int'(presente), 1);
        step();
        check("lit_personaje", int'(presente), 2);

        // Menu: OK without hero, other key, then OK with hero
        key = 5'd13; cambio = 1'b0; kp = 1'b1; step();
        check("lit_ok_no_hero", int'(presente), 2);
        kp = 1'b0; step();
        key = 5'd10; cambio = 1'b1; kp = 1'b1; step();
        check("lit_other_key", int'(presente), 2);
        kp = 1'b0; step();
        key = 5'd13; kp = 1'b1; step();
        check("lit_juego", int'(presente), 3);
        check("lit_inicio_on", int'(inicio), 1);
        kp = 1'b0; step();
        check("lit_inicio_off", int'(inicio), 0);

        // Simultaneous HP-zero: defeat wins, GP lasts GPC cycles
        step();
        vh = 1'b1; ve = 1'b1; step();
        check("lit_gp", int'(presente), 4);
        check("lit_gp_vd", int'(v_d), 1);
        vh = 1'b0; ve = 1'b0;
        steps(GPC - 1);
        check("lit_gp_hold", int'(presente), 4);
        step();
        check("lit_yn", int'(presente), 5);
        check("lit_yn_vd", int'(v_d), 1);

        // Held key 10: exactly one transition
        key = 5'd10; kp = 1'b1; step();
        check("lit_si", int'(presente), 2);
        check("lit_si_vd", int'(v_d), 0);
        steps(19);
        kp = 1'b0; step();

        // Key 11 in YN powers off
        goto_yn();
        key = 5'd11; kp = 1'b1; step();
        check("lit_no", int'(presente), 0);
        check("lit_no_enc", int'(encendido), 0);
        check("lit_no_vd", int'(v_d), 0);
        steps(5);
        kp = 1'b0; step();

        // Power event on the cycle GP expires
        power_pulse();
        steps(HOLA - 1);
        key = 5'd13; cambio = 1'b1; kp = 1'b1; step();
        kp = 1'b0;
        vh = 1'b1; step();
        vh = 1'b0;
        check("lit_gp2_vd", int'(v_d), 1);
        steps(GPC - 1);
        btn = 1'b1; step();
        check("lit_pwr_over_gp", int'(presente), 0);
        check("lit_pwr_over_gp_vd", int'(v_d), 0);
        btn = 1'b0; step();

        // Reset during the inicio pulse, with the button held through release
        to_juego();
        check("lit_inicio2", int'(inicio), 1);
        rst = 1'b1; btn = 1'b1; step();
        check("lit_rst_presente", int'(presente), 0);
        check("lit_rst_inicio", int'(inicio), 0);
        check("lit_rst_enc", int'(encendido), 0);
        step();
        rst = 1'b0;
        steps(3);
        check("lit_held_btn", int'(presente), 0);
        btn = 1'b0; step();
        btn = 1'b1; step();
        check("lit_repress", int'(presente), 1);
        btn = 1'b0; step();

        // Idle behaviour in YN
        goto_yn();
        steps(IDLE - 1);
        check("lit_idle_hold", int'(presente), 5);
        step();
`ifdef IDLE_TIMEOUT_EN
        check("lit_idle_timeout", int'(presente), 1);
        check("lit_idle_vd", int'(v_d), 0);
`else
        check("lit_no_timeout", int'(presente), 5);
        check("lit_no_timeout_vd", int'(v_d), 2);
`endif
        steps(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_estado.md
CONTROL_ESTADO -- requirements
Module: control_estado

Interface
REQ-001 Parameter CLK_HZ, default 27_000_000, system clock frequency in Hz.
REQ-002 Parameter HOLA_CYC, default 54_000_000, cycles spent in HOLA (2 s).
REQ-003 Parameter GP_CYC, default 81_000_000, cycles spent in GP (3 s).
REQ-004 Parameter IDLE_CYC, default 810_000_000, inactivity limit in cycles (30 s); used only under REQ-027.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 btn_encendido  in  1  power button level, already debounced.
REQ-008 keypad_pressed  in  1  keypad key-down level.
REQ-009 key  in  5  keypad code, valid while keypad_pressed=1.
REQ-010 cambio  in  1  from menu; 1 = a hero other than 0 is selected.
REQ-011 vida_heroe_cero  in  1  hero HP reached zero (level).
REQ-012 vida_enemigo_cero  in  1  enemy HP reached zero (level).
REQ-013 presente  out  4  current state: APAGADO=0, HOLA=1, PERSONAJE=2, JUEGO=3, GP=4, YN=5.
REQ-014 encendido  out  1  1 in every state except APAGADO.
REQ-015 v_d  out  2  result: 0 = none, 1 = defeat, 2 = victory.
REQ-016 inicio  out  1  one-cycle pulse on entry to JUEGO; clears game data downstream.

Function
REQ-017 A key event SHALL be a rising edge of keypad_pressed (registered previous value): exactly one event per press, sampled with key in the same cycle, and acted on one cycle after the edge.
REQ-018 A power event SHALL be a rising edge of btn_encendido. In APAGADO it moves to HOLA; in any other state it moves to APAGADO with v_d=0. It has priority over every other transition in the same cycle.
REQ-019 All outputs SHALL be registered; presente changes one cycle after the triggering condition is sampled.
REQ-020 HOLA: the timer counts from 0 and the FSM moves to PERSONAJE when the count reaches HOLA_CYC-1. The time spent in HOLA is exactly HOLA_CYC cycles.
REQ-021 PERSONAJE: a key event with key=13 and cambio=1 moves to JUEGO and asserts inicio for one cycle. key=13 with cambio=0 is ignored. All other keys are ignored because the menu consumes them.
REQ-022 JUEGO: vida_heroe_cero=1 moves to GP with v_d=1. Otherwise vida_enemigo_cero=1 moves to GP with v_d=2. If both are 1 in the same cycle, defeat wins (v_d=1).
REQ-023 GP: v_d is held and the FSM moves to YN after exactly GP_CYC cycles.
REQ-024 YN: key=10 moves to PERSONAJE with v_d=0. key=11 moves to APAGADO with v_d=0. Other keys are ignored. v_d is held while in YN.
REQ-025 The timer SHALL be 32 bits, cleared on every state change, and saturate (never wrap) in states that do not use it.
REQ-026 Codes 6..15 on presente SHALL never be produced. An illegal internal state recovers to APAGADO on the next cycle.

Configuration
REQ-027 Macro IDLE_TIMEOUT_EN. When defined, IDLE_CYC cycles in PERSONAJE or YN without a key event move the FSM to HOLA with v_d=0, and every key event restarts the count. When undefined, there is no timeout and PERSONAJE/YN wait forever.

Reset
REQ-028 While rst=1 on a clock edge: presente=APAGADO, encendido=0, v_d=0, inicio=0, timer=0, and both edge-detector registers=0.
REQ-029 A reset asserted mid-state (including during the inicio pulse) SHALL abort the operation with no residual pulse.
REQ-030 A button or keypad held high through reset release SHALL NOT produce an event until it is released and pressed again.

Structure
REQ-031 Package estados_pkg SHALL hold: the state codes, the key codes (KEY_SI=10, KEY_NO=11, KEY_HEROE=12, KEY_OK=13), and the v_d codes (VD_NADA, VD_PIERDE, VD_GANA); the menu shall use the same package.
REQ-032 Sub-module detector_flanco (1-bit registered rising-edge detector with synchronous reset) SHALL be instantiated twice: once for power, once for keypad.

Verification (HOLA_CYC=4, GP_CYC=3, IDLE_CYC=8 in bench)
REQ-033 Reset, then power pulse -> presente=1 and encendido=1; after 4 cycles presente=2.
REQ-034 In PERSONAJE, key=13 with cambio=0 -> stays 2; with cambio=1 -> presente=3 and inicio high for exactly 1 cycle.
REQ-035 In JUEGO, both HP-zero flags raised in the same cycle -> presente=4, v_d=1; 3 cycles later presente=5 with v_d still 1.
REQ-036 In YN, key=10 held for 20 cycles -> a single transition to presente=2 with v_d=0. Repeat with key=11 -> presente=0, encendido=0.
REQ-037 Power pulse in the same cycle that GP expires -> presente=0. A separate run with rst pulsed during JUEGO -> all outputs 0 next cycle.
REQ-038 IDLE_TIMEOUT_EN defined: 8 idle cycles in YN -> presente=1, v_d=0. Undefined: presente stays 5.
